// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-add per clock, start/busy/done handshake
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  // Single full-adder cell working on the current LSBs and the held carry.
  always_comb begin
    fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c     = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    last_bit = (cnt_q == LAST);
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state: accept in IDLE, run WIDTH bits, one DONE cycle, back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per RUN edge, publish result on the last bit.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cIn;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        a_d            = a_q >> 1;
        b_d            = b_q >> 1;
        sum_d          = sum_q >> 1;
        sum_d[WIDTH-1] = fa_s;
        carry_d        = fa_c;
        cnt_d          = cnt_q + CW'(1);
        if (last_bit) begin
          s_d    = sum_d;
          cout_d = fa_c;
        end
      end
      default: begin
      end
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
      end
    endcase
  end

  assign s    = s_q;
  assign cOut = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [7:0] a0, b0;
  logic [0:0] a1, b1;
  logic       cin0, cin1;
  logic       busy0, done0, cout0;
  logic       busy1, done1, cout1;
  logic [7:0] s0;
  logic [0:0] s1;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cIn(cin0),
    .busy(busy0), .done(done0), .s(s0), .cOut(cout0)
  );

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cIn(cin1),
    .busy(busy1), .done(done1), .s(s1), .cOut(cout1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   width[2] = '{8, 1};
  int   nf[2];
  int   e0[2];
  int   sres[2];
  int   e = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int j, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (W=%0d) at edge %0d: got %0h expected %0h", name, width[j], e, act, exp);
    end
  endtask

  // One clock of stimulus; the reference model decides acceptance from its own timing.
  task automatic step(input int k, input bit st, input int av, input int bv, input bit cv, input bit r);
    int w;
    int m;
    exp_t x;
    rst    = r;
    start0 = (k == 0) ? st : 1'b0;
    start1 = (k == 1) ? st : 1'b0;
    w = width[k];
    m = (1 << w) - 1;
    if (k == 0) begin
      a0 = 8'(av); b0 = 8'(bv); cin0 = cv;
    end else begin
      a1 = 1'(av); b1 = 1'(bv); cin1 = cv;
    end
    @(posedge clk);
    e++;
    if (r) begin
      q0.delete();
      q1.delete();
      for (int j = 0; j < 2; j++) begin
        nf[j]   = e + 1;
        e0[j]   = -1000;
        sres[j] = 0;
      end
    end else if (st && e >= nf[k]) begin
      x.val = (av & m) + (bv & m) + int'(cv);
      x.due = e + w;
      if (k == 0) q0.push_back(x); else q1.push_back(x);
      e0[k] = e;
      nf[k] = e + w + 2;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: pop expected results when done appears, check handshake and held outputs every cycle.
  always @(negedge clk) begin
    if (e >= 1) begin
      for (int j = 0; j < 2; j++) begin
        int   w;
        int   d;
        bit   bz, dn;
        int   sv, cv;
        exp_t x;
        w  = width[j];
        d  = e - e0[j];
        bz = (j == 0) ? busy0 : busy1;
        dn = (j == 0) ? done0 : done1;
        sv = (j == 0) ? int'(s0) : int'(s1);
        cv = (j == 0) ? int'(cout0) : int'(cout1);
        chk("busy", j, int'(bz), int'(d >= 0 && d < w));
        chk("done", j, int'(dn), int'(d == w));
        if (dn) begin
          if ((j == 0 && q0.size() == 0) || (j == 1 && q1.size() == 0)) begin
            chk("unexpected_done", j, 1, 0);
          end else begin
            x = (j == 0) ? q0.pop_front() : q1.pop_front();
            chk("done_latency", j, e, x.due);
            sres[j] = x.val;
          end
        end
        chk("s", j, sv, sres[j] & ((1 << w) - 1));
        chk("cOut", j, cv, (sres[j] >> w) & 1);
      end
    end
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    for (int j = 0; j < 2; j++) begin
      nf[j] = 0; e0[j] = -1000; sres[j] = 0;
    end

    step(0, 1'b0, 0, 0, 1'b0, 1'b1);
    step(0, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(2);

    step(0, 1'b1, 'h3C, 'h0F, 1'b0, 1'b0);
    idle(10);
    step(0, 1'b1, 'hFF, 'h01, 1'b0, 1'b0);
    idle(10);
    step(0, 1'b1, 'hA5, 'h5A, 1'b1, 1'b0);
    idle(10);
    step(0, 1'b1, 'h00, 'h00, 1'b0, 1'b0);
    idle(10);

    // Start re-pulsed during RUN cycles 3 and 8 and in the DONE cycle.
    step(0, 1'b1, 'h12, 'h34, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      if (i == 3 || i == 8 || i == 9) step(0, 1'b1, 'hEE, 'hDD, 1'b1, 1'b0);
      else idle(1);
    end
    idle(4);

    // Reset mid-add aborts it.
    step(0, 1'b1, 'hFF, 'h01, 1'b0, 1'b0);
    idle(3);
    step(0, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(2);
    step(0, 1'b1, 'h80, 'h81, 1'b1, 1'b0);
    idle(10);

    // WIDTH=1 exhaustive truth table.
    for (int v = 0; v < 8; v++) begin
      step(1, 1'b1, v & 1, (v >> 1) & 1, v[2], 1'b0);
      step(1, 1'b0, 0, 0, 1'b0, 1'b0);
      step(1, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    idle(2);

    // start held high with new random operands every cycle.
    for (int i = 0; i < 40; i++) begin
      step(0, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end
    idle(12);

    // Random starts at random gaps on both widths.
    for (int i = 0; i < 60; i++) begin
      int k;
      k = int'($urandom_range(0, 1));
      step(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b0);
    end
    idle(12);

    chk("pending_w8", 0, q0.size(), 0);
    chk("pending_w1", 1, q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
